sa_deskew: RTL and testbench
============================

// Module: sa_deskew
// PURPOSE
//   Output-side counterpart of the systolic-array input skew delay lines.
//   Result lanes leave the array staggered: lane i is produced i cycles after lane 0.
//   This block re-aligns them into one row vector per result.
//   Aligned rows are buffered in a small FIFO and handed downstream over a valid/ready handshake.
//   The array is free-running and cannot be stalled, so input overflow is flagged, not back-pressured.
// PARAMETERS
//   LANES      4   number of result lanes (array columns), >=1
//   DAT_WIDTH  16  bits per lane
//   FIFO_DEPTH 4   aligned rows buffered; power of 2, >=2
// PORTS
//   clk        in   1                    clock; all logic on posedge
//   rst        in   1                    reset, synchronous, active-high
//   i_dat_vld  in   LANES                per-lane valid; bit i = lane i
//   i_dat      in   LANES*DAT_WIDTH      lane i at [i*DAT_WIDTH +: DAT_WIDTH]
//   i_rdy      in   1                    downstream ready
//   o_dat_vld  out  1                    aligned row available
//   o_dat      out  LANES*DAT_WIDTH      aligned row, same lane packing as i_dat
//   o_count    out  $clog2(FIFO_DEPTH+1) rows currently held in FIFO
//   o_err_skew out  1                    sticky: lane valids disagreed after alignment
//   o_err_ovf  out  1                    sticky: aligned row dropped, FIFO full
//   i_clr_err  in   1                    clears both sticky flags
// BEHAVIOUR
//   - Reset (rst=1 at posedge), next cycle:
//     - o_dat_vld=0, o_count=0, o_err_skew=0, o_err_ovf=0.
//     - All delay-line valids are cleared. Delay-line data are don't-care.
//     - Rows in flight or stored are discarded. This holds for reset mid-stream too.
//   - Alignment:
//     - Lane i (valid and data) passes through LANES-1-i registers. Lane LANES-1 has none.
//     - Lane 0 sampled in cycle t and lane i sampled in cycle t+i meet in cycle t+LANES-1.
//   - Row formation (cycle t+LANES-1, aligned valids a[LANES-1:0]):
//     - All ones: a row is presented for push.
//     - All zeros: nothing happens.
//     - Mixed: no push; o_err_skew sets on the next edge; the partial row is discarded.
//   - FIFO push/pop:
//     - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
//     - Otherwise the row is dropped and o_err_ovf sets.
//     - Pop occurs when o_dat_vld & i_rdy.
//     - o_dat/o_dat_vld come straight from the FIFO head register; no fall-through.
//     - A row pushed at the end of cycle t+LANES-1 is visible in cycle t+LANES at the earliest.
//     - Total latency, lane 0 input to o_dat_vld, is LANES cycles.
//     - Push and pop in the same cycle: count unchanged, order preserved.
//     - Pointers wrap modulo FIFO_DEPTH.
//     - o_dat holds stable while o_dat_vld=1 and i_rdy=0.
//   - Sticky flags:
//     - Cleared by rst or i_clr_err.
//     - If an error event coincides with i_clr_err, the set wins.
//   - LANES=1: no alignment registers; the skew check is trivially never raised.
// TESTING  (LANES=4, DAT_WIDTH=16, FIFO_DEPTH=4)
//   1 one row: lane i valid with 16'h10+i in cycle i, i_rdy=1
//     -> o_dat_vld=1 for exactly cycle 4, o_dat={16'h13,16'h12,16'h11,16'h10}.
//   2 8 back-to-back rows (row k: lane i = 16'h100*k+i), i_rdy=1
//     -> 8 consecutive o_dat_vld cycles in order, o_count<=1, no flags.
//   3 i_rdy=0, 6 rows streamed
//     -> o_count reaches 4, rows 5 and 6 dropped, o_err_ovf=1.
//     -> then i_rdy=1 drains rows 1..4 in order, o_count returns to 0.
//   4 FIFO full, i_rdy=1 in the cycle a new row aligns
//     -> pop+push, o_count stays 4, o_err_ovf stays 0.
//   5 lane 2 valid one cycle late
//     -> o_err_skew=1, no row emitted for that set.
//     -> i_clr_err pulse clears it, next good row emitted normally.
//   6 rst=1 for 1 cycle with 2 rows in flight and 2 stored
//     -> next cycle o_dat_vld=0, o_count=0; none of those 4 rows ever appear.

Source files
------------

// File: rtl/sa_deskew.sv
// Output deskew for a systolic array: re-aligns staggered result lanes into rows
// and buffers complete rows in a small FIFO with a valid/ready output.
module sa_deskew #(
    parameter int LANES      = 4,
    parameter int DAT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [LANES-1:0]                   i_dat_vld,
    input  logic [LANES*DAT_WIDTH-1:0]         i_dat,
    input  logic                               i_rdy,
    output logic                               o_dat_vld,
    output logic [LANES*DAT_WIDTH-1:0]         o_dat,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count,
    output logic                               o_err_skew,
    output logic                               o_err_ovf,
    input  logic                               i_clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int RW = LANES * DAT_WIDTH;

    logic [LANES-1:0] aln_vld_s;
    logic [RW-1:0]    aln_dat_s;

    // Lane g is delayed by LANES-1-g cycles so that all lanes of one result meet.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int DLY = LANES - 1 - g;
        if (DLY == 0) begin : g_direct
            assign aln_vld_s[g]                          = i_dat_vld[g];
            assign aln_dat_s[g*DAT_WIDTH +: DAT_WIDTH]   = i_dat[g*DAT_WIDTH +: DAT_WIDTH];
        end else begin : g_delay
            logic [DLY-1:0]       vld_sh_r;
            logic [DAT_WIDTH-1:0] dat_sh_r [DLY];

            // Shift valid and data of this lane through its delay line.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_sh_r <= '0;
                    for (int k = 0; k < DLY; k++) begin
                        dat_sh_r[k] <= '0;
                    end
                end else begin
                    vld_sh_r[0] <= i_dat_vld[g];
                    dat_sh_r[0] <= i_dat[g*DAT_WIDTH +: DAT_WIDTH];
                    for (int k = 1; k < DLY; k++) begin
                        vld_sh_r[k] <= vld_sh_r[k-1];
                        dat_sh_r[k] <= dat_sh_r[k-1];
                    end
                end
            end

            assign aln_vld_s[g]                        = vld_sh_r[DLY-1];
            assign aln_dat_s[g*DAT_WIDTH +: DAT_WIDTH] = dat_sh_r[DLY-1];
        end
    end

    logic              row_full_s;
    logic              row_skew_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW-1:0]     rd_ptr_nxt_s;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_nxt_s;
    logic [RW-1:0]     head_nxt_s;
    logic [RW-1:0]     mem_r [FIFO_DEPTH];

    // Classify the aligned lane valids and decide push/pop for this cycle.
    always_comb begin
        row_full_s   = &aln_vld_s;
        row_skew_s   = (|aln_vld_s) & ~(&aln_vld_s);
        pop_s        = o_dat_vld & i_rdy;
        push_s       = row_full_s & ((count_r != CW'(FIFO_DEPTH)) | pop_s);
        drop_s       = row_full_s & ~push_s;
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        // A row written into the slot that becomes the head must bypass the array read.
        if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = aln_dat_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Row storage; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= aln_dat_s;
        end
    end

    // FIFO pointers, occupancy and the registered head presented downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            o_dat_vld <= 1'b0;
            o_dat     <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r  <= rd_ptr_nxt_s;
            count_r   <= count_nxt_s;
            o_dat_vld <= (count_nxt_s != CW'(0));
            o_dat     <= head_nxt_s;
        end
    end

    assign o_count = count_r;

    // Sticky error flags; a new event takes priority over a clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err_skew <= 1'b0;
            o_err_ovf  <= 1'b0;
        end else begin
            if (row_skew_s) begin
                o_err_skew <= 1'b1;
            end else if (i_clr_err) begin
                o_err_skew <= 1'b0;
            end
            if (drop_s) begin
                o_err_ovf <= 1'b1;
            end else if (i_clr_err) begin
                o_err_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sa_deskew.sv
// Directed self-checking bench for sa_deskew (LANES=4, DAT_WIDTH=16, FIFO_DEPTH=4).
module tb_sa_deskew;

    logic        clk;
    logic        rst;
    logic [3:0]  i_dat_vld;
    logic [63:0] i_dat;
    logic        i_rdy;
    logic        o_dat_vld;
    logic [63:0] o_dat;
    logic [2:0]  o_count;
    logic        o_err_skew;
    logic        o_err_ovf;
    logic        i_clr_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] popped[$];
    int          run_len;
    int          max_run;
    int          max_cnt;

    sa_deskew #(.LANES(4), .DAT_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_dat_vld  (i_dat_vld),
        .i_dat      (i_dat),
        .i_rdy      (i_rdy),
        .o_dat_vld  (o_dat_vld),
        .o_dat      (o_dat),
        .o_count    (o_count),
        .o_err_skew (o_err_skew),
        .o_err_ovf  (o_err_ovf),
        .i_clr_err  (i_clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] row_of(input logic [15:0] base, input int k);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*16 +: 16] = base + 16'(k * 256) + 16'(i);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record this cycle's outputs, then advance to just after the next edge.
    task automatic tick();
        if (o_dat_vld === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (o_dat_vld === 1'b1 && i_rdy === 1'b1) popped.push_back(o_dat);
        if (o_count !== 3'bxxx && int'(o_count) > max_cnt) max_cnt = int'(o_count);
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    // Drive rows skewed as the array emits them: lane i of row r in cycle r+i.
    task automatic stream(input int nrows, input int kbase, input logic [15:0] base, input int stop_c);
        for (int c = 0; c < stop_c; c++) begin
            i_dat_vld = 4'b0000;
            i_dat     = 64'h0;
            for (int i = 0; i < 4; i++) begin
                int r;
                r = c - i;
                if (r >= 0 && r < nrows) begin
                    i_dat_vld[i]     = 1'b1;
                    i_dat[i*16 +: 16] = base + 16'((kbase + r) * 256) + 16'(i);
                end
            end
            tick();
        end
        i_dat_vld = 4'b0000;
    endtask

    task automatic check_popped(input string tag, input int n, input int kbase);
        check({tag, "_num"}, 64'(popped.size()), 64'(n));
        for (int k = 0; k < n; k++) begin
            check(tag, (k < popped.size()) ? popped[k] : 64'hx, row_of(16'h0, kbase + k));
        end
    endtask

    initial begin
        rst = 1'b1; i_dat_vld = 4'b0000; i_dat = 64'h0; i_rdy = 1'b0; i_clr_err = 1'b0;
        run_len = 0; max_run = 0; max_cnt = 0;
        @(posedge clk); #1;
        flush(2);
        rst = 1'b0;
        check("rst_vld",  64'(o_dat_vld),  64'h0);
        check("rst_cnt",  64'(o_count),    64'h0);
        check("rst_skew", 64'(o_err_skew), 64'h0);
        check("rst_ovf",  64'(o_err_ovf),  64'h0);

        // 1: single row, latency LANES
        i_rdy = 1'b1; popped.delete();
        stream(1, 0, 16'h10, 4);
        check("t1_vld", 64'(o_dat_vld), 64'h1);
        check("t1_dat", o_dat, {16'h13, 16'h12, 16'h11, 16'h10});
        tick();
        check("t1_vld_off", 64'(o_dat_vld), 64'h0);
        check("t1_num", 64'(popped.size()), 64'h1);

        // 2: eight back-to-back rows
        popped.delete(); run_len = 0; max_run = 0; max_cnt = 0;
        stream(8, 1, 16'h0, 11);
        flush(5);
        check_popped("t2_row", 8, 1);
        check("t2_run", 64'(max_run), 64'd8);
        check("t2_cnt_le1", 64'(max_cnt <= 1), 64'h1);
        check("t2_skew", 64'(o_err_skew), 64'h0);
        check("t2_ovf",  64'(o_err_ovf),  64'h0);

        // 3: overflow with downstream stalled, then drain
        i_rdy = 1'b0; popped.delete();
        stream(6, 16'h20, 16'h0, 9);
        flush(3);
        check("t3_cnt_full", 64'(o_count), 64'd4);
        check("t3_ovf", 64'(o_err_ovf), 64'h1);
        check("t3_head", o_dat, row_of(16'h0, 16'h20));
        tick();
        check("t3_head_hold", o_dat, row_of(16'h0, 16'h20));
        i_rdy = 1'b1;
        flush(6);
        check_popped("t3_row", 4, 16'h20);
        check("t3_cnt_empty", 64'(o_count), 64'h0);
        i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
        check("t3_ovf_clr", 64'(o_err_ovf), 64'h0);

        // 4: full FIFO, pop coincides with a newly aligned row
        i_rdy = 1'b0; popped.delete();
        stream(4, 16'h30, 16'h0, 7);
        flush(3);
        check("t4_cnt_full", 64'(o_count), 64'd4);
        for (int c = 0; c < 4; c++) begin
            i_dat_vld = 4'b0001 << c;
            i_dat     = 64'h0;
            i_dat[c*16 +: 16] = 16'h3400 + 16'(c);
            i_rdy     = (c == 3);
            tick();
        end
        i_dat_vld = 4'b0000; i_rdy = 1'b0;
        check("t4_cnt_same", 64'(o_count), 64'd4);
        check("t4_ovf", 64'(o_err_ovf), 64'h0);
        check("t4_head", o_dat, row_of(16'h0, 16'h31));
        i_rdy = 1'b1;
        flush(6);
        check_popped("t4_row", 5, 16'h30);

        // 5: lane 2 one cycle late, error set beats a simultaneous clear
        popped.delete();
        i_dat = 64'h0;
        i_dat_vld = 4'b0001; i_dat[15:0]  = 16'h4000; tick();
        i_dat_vld = 4'b0010; i_dat[31:16] = 16'h4001; tick();
        i_dat_vld = 4'b0000; tick();
        i_dat_vld = 4'b1100; i_dat[47:32] = 16'h4002; i_dat[63:48] = 16'h4003;
        i_clr_err = 1'b1; tick();
        check("t5_set_wins", 64'(o_err_skew), 64'h1);
        i_clr_err = 1'b0; i_dat_vld = 4'b0000;
        flush(6);
        check("t5_skew", 64'(o_err_skew), 64'h1);
        check("t5_no_row", 64'(popped.size()), 64'h0);
        check("t5_cnt", 64'(o_count), 64'h0);
        i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
        check("t5_skew_clr", 64'(o_err_skew), 64'h0);
        stream(1, 16'h50, 16'h0, 4);
        flush(3);
        check_popped("t5_good", 1, 16'h50);
        check("t5_skew_after", 64'(o_err_skew), 64'h0);

        // 6: reset mid-stream discards stored and in-flight rows
        i_rdy = 1'b0; popped.delete();
        stream(2, 16'h60, 16'h0, 5);
        flush(3);
        check("t6_cnt_pre", 64'(o_count), 64'd2);
        stream(2, 16'h62, 16'h0, 2);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_vld", 64'(o_dat_vld), 64'h0);
        check("t6_cnt", 64'(o_count), 64'h0);
        i_rdy = 1'b1;
        flush(8);
        check("t6_none", 64'(popped.size()), 64'h0);
        check("t6_skew", 64'(o_err_skew), 64'h0);
        check("t6_ovf",  64'(o_err_ovf),  64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
